// File: rtl/pc_bpu.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit direction counters.
// Optional statistics counters are built when BPU_STATS_EN is defined.
module pc_bpu #(
  parameter int unsigned              DATA_WIDTH  = 32,
  parameter int unsigned              BTB_ENTRIES = 16,
  parameter logic [DATA_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_f,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [DATA_WIDTH-1:0] ex_pred_target,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] inc_PC,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] branch_target,
  output logic                  flush,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = DATA_WIDTH - IDX_W - 2;

  logic                  valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]      tag_q    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [BTB_ENTRIES];
  logic [1:0]            ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0]      f_idx;
  logic [TAG_W-1:0]      f_tag;
  logic                  f_hit;
  logic [IDX_W-1:0]      ex_idx;
  logic [TAG_W-1:0]      ex_tag;
  logic                  ex_hit;
  logic [1:0]            ctr_nxt;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] redirect_pc;

  // Fetch-side lookup
  assign f_idx         = PC[IDX_W+1:2];
  assign f_tag         = PC[DATA_WIDTH-1:IDX_W+2];
  assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign inc_PC        = PC + DATA_WIDTH'(4);
  assign predict_taken = f_hit && ctr_q[f_idx][1];
  assign branch_target = f_hit ? target_q[f_idx] : inc_PC;

  // Resolution side
  assign ex_idx      = ex_pc[IDX_W+1:2];
  assign ex_tag      = ex_pc[DATA_WIDTH-1:IDX_W+2];
  assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                    (ex_taken && (ex_target != ex_pred_target)));
  assign flush       = mispredict && !rst;
  assign redirect_pc = ex_taken ? ex_target : ex_pc + DATA_WIDTH'(4);

  always_comb begin
    ctr_nxt = ctr_q[ex_idx];
    if (ex_taken) begin
      if (ctr_q[ex_idx] != 2'b11) ctr_nxt = ctr_q[ex_idx] + 2'b01;
    end else begin
      if (ctr_q[ex_idx] != 2'b00) ctr_nxt = ctr_q[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC <= RESET_PC;
    end else if (mispredict) begin
      PC <= redirect_pc;
    end else if (en_f) begin
      PC <= predict_taken ? branch_target : inc_PC;
    end
  end

  // BTB training; contents are wiped on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (ex_valid) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_nxt;
        if (ex_taken) target_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] br_q;
  logic [31:0] mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (ex_valid)   br_q <= br_q + 32'd1;
      if (mispredict) mp_q <= mp_q + 32'd1;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_pc_bpu.sv
// Scoreboard bench for pc_bpu: expected fetch PCs are queued as stimulus is driven
// and checked one cycle later; prediction/flush outputs are checked inline.
module tb_pc_bpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_f;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc;
  logic [31:0] inc_pc;
  logic        predict_taken;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  pc_bpu #(.DATA_WIDTH(32), .BTB_ENTRIES(16), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .en_f(en_f),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .PC(pc), .inc_PC(inc_pc), .predict_taken(predict_taken),
    .branch_target(branch_target), .flush(flush),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Scoreboard: each queued PC must appear just after the next rising edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_pc = sb.pop_front();
      n_vec++;
      if (pc !== exp_pc) begin
        n_err++;
        $display("FAIL pc_seq: got %h want %h", pc, exp_pc);
      end
    end
  end

  task automatic set_ex(input logic v, input logic [31:0] p, input logic tk,
                        input logic [31:0] t, input logic ptk, input logic [31:0] pt);
    ex_valid = v; ex_pc = p; ex_taken = tk; ex_target = t;
    ex_pred_taken = ptk; ex_pred_target = pt;
  endtask

  task automatic idle();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic chk_flush(input string name, input logic want);
    n_vec++;
    if (flush !== want) begin
      n_err++;
      $display("FAIL %s flush: got %b want %b", name, flush, want);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; en_f = 1'b1; idle(); sb.push_back(32'h100);
    // Reset must override a simultaneous mispredict and its training
    @(negedge clk); set_ex(1'b1, 32'h108, 1'b1, 32'h300, 1'b0, 32'h0); #1;
    n_vec++;
    if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b want 0", flush); end
    sb.push_back(32'h100);
    @(negedge clk); rst = 1'b0; idle(); #1;
    n_vec++;
    if (predict_taken !== 1'b0 || flush !== 1'b0 || inc_pc !== 32'h104) begin
      n_err++;
      $display("FAIL rst_outputs: got pt=%b fl=%b inc=%h want pt=0 fl=0 inc=104",
               predict_taken, flush, inc_pc);
    end
    n_vec++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      n_err++;
      $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
    end
    sb.push_back(32'h104);
    @(negedge clk); sb.push_back(32'h108);
  endtask

  task automatic test_cold_taken();
    @(negedge clk); set_ex(1'b1, 32'h108, 1'b1, 32'h100, 1'b0, 32'h0); #1;
    chk_flush("cold", 1'b1); sb.push_back(32'h100);
    @(negedge clk); idle(); sb.push_back(32'h104);
    @(negedge clk); sb.push_back(32'h108);
    @(negedge clk); #1;
    n_vec++;
    if (predict_taken !== 1'b1 || branch_target !== 32'h100) begin
      n_err++;
      $display("FAIL cold_hit: got pt=%b tgt=%h want pt=1 tgt=100", predict_taken, branch_target);
    end
    sb.push_back(32'h100);
  endtask

  task automatic test_hysteresis();
    @(negedge clk); en_f = 1'b0; set_ex(1'b1, 32'h108, 1'b1, 32'h100, 1'b1, 32'h100); #1;
    chk_flush("hys_up", 1'b0); sb.push_back(32'h100);
    @(negedge clk); set_ex(1'b1, 32'h108, 1'b0, 32'h0, 1'b1, 32'h100); #1;
    chk_flush("hys_nt1", 1'b1); sb.push_back(32'h10C);
    @(negedge clk); set_ex(1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h108); #1;
    chk_flush("hys_go108", 1'b1); sb.push_back(32'h108);
    // Counter at 2'b10; lookup must see pre-write value while it decrements
    @(negedge clk); set_ex(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 32'h0); #1;
    n_vec++;
    if (predict_taken !== 1'b1) begin n_err++; $display("FAIL hys_weak_t: got %b want 1", predict_taken); end
    sb.push_back(32'h108);
    @(negedge clk); idle(); #1;
    n_vec++;
    if (predict_taken !== 1'b0) begin n_err++; $display("FAIL hys_weak_nt: got %b want 0", predict_taken); end
    sb.push_back(32'h108);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_ex(1'b1, 32'h108, 1'b1, 32'h100, 1'b1, 32'h100); sb.push_back(32'h108);
    end
    @(negedge clk); set_ex(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 32'h0); #1;
    n_vec++;
    if (predict_taken !== 1'b1) begin n_err++; $display("FAIL hys_sat: got %b want 1", predict_taken); end
    sb.push_back(32'h108);
    @(negedge clk); idle(); #1;
    n_vec++;
    if (predict_taken !== 1'b1) begin n_err++; $display("FAIL hys_sat_dec: got %b want 1", predict_taken); end
    sb.push_back(32'h108);
  endtask

  task automatic test_stall_redirect();
    @(negedge clk); set_ex(1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 32'h0); #1;
    chk_flush("st_to200", 1'b1); sb.push_back(32'h200);
    @(negedge clk); idle(); #1;
    chk_flush("st_hold", 1'b0); sb.push_back(32'h200);
    @(negedge clk); set_ex(1'b1, 32'h1F0, 1'b0, 32'h0, 1'b1, 32'h1F4); #1;
    chk_flush("st_nt", 1'b1); sb.push_back(32'h1F4);
    @(negedge clk); set_ex(1'b1, 32'h1F4, 1'b1, 32'h200, 1'b1, 32'h204); #1;
    chk_flush("st_badtgt", 1'b1); sb.push_back(32'h200);
  endtask

  task automatic test_tag_alias();
    @(negedge clk); set_ex(1'b1, 32'h144, 1'b0, 32'h0, 1'b1, 32'h148); sb.push_back(32'h148);
    @(negedge clk); idle(); en_f = 1'b1; #1;
    n_vec++;
    if (predict_taken !== 1'b0) begin n_err++; $display("FAIL alias_miss: got %b want 0", predict_taken); end
    sb.push_back(32'h14C);
    @(negedge clk); en_f = 1'b0; set_ex(1'b1, 32'h148, 1'b1, 32'h400, 1'b0, 32'h0); #1;
    chk_flush("alias_train", 1'b1); sb.push_back(32'h400);
    @(negedge clk); set_ex(1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h108); sb.push_back(32'h108);
    @(negedge clk); idle(); #1;
    n_vec++;
    if (predict_taken !== 1'b0) begin n_err++; $display("FAIL alias_evicted: got %b want 0", predict_taken); end
    sb.push_back(32'h108);
    @(negedge clk); set_ex(1'b1, 32'h144, 1'b0, 32'h0, 1'b1, 32'h148); sb.push_back(32'h148);
    @(negedge clk); idle(); en_f = 1'b1; #1;
    n_vec++;
    if (predict_taken !== 1'b1 || branch_target !== 32'h400) begin
      n_err++;
      $display("FAIL alias_new: got pt=%b tgt=%h want pt=1 tgt=400", predict_taken, branch_target);
    end
    sb.push_back(32'h400);
  endtask

  task automatic test_wrap();
    @(negedge clk); en_f = 1'b0; set_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0); #1;
    chk_flush("wrap", 1'b1); sb.push_back(32'h0);
    @(negedge clk); idle(); en_f = 1'b1; #1;
    n_vec++;
    if (inc_pc !== 32'h4) begin n_err++; $display("FAIL wrap_inc: got %h want 00000004", inc_pc); end
    sb.push_back(32'h4);
  endtask

  task automatic test_stats();
    logic [31:0] want_br;
    logic [31:0] want_mp;
`ifdef BPU_STATS_EN
    want_br = 32'd5; want_mp = 32'd2;
`else
    want_br = 32'd0; want_mp = 32'd0;
`endif
    @(negedge clk); rst = 1'b1; en_f = 1'b0; idle(); sb.push_back(32'h100);
    @(negedge clk); sb.push_back(32'h100);
    @(negedge clk); rst = 1'b0; set_ex(1'b1, 32'h100, 1'b1, 32'h180, 1'b0, 32'h0); sb.push_back(32'h180);
    @(negedge clk); set_ex(1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h180); sb.push_back(32'h180);
    @(negedge clk); set_ex(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0); sb.push_back(32'h180);
    @(negedge clk); set_ex(1'b1, 32'h144, 1'b0, 32'h0, 1'b1, 32'h148); sb.push_back(32'h148);
    // Entry at 0x148 existed before reset and must now be gone
    @(negedge clk); set_ex(1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h180); #1;
    n_vec++;
    if (predict_taken !== 1'b0) begin n_err++; $display("FAIL btb_cleared: got %b want 0", predict_taken); end
    sb.push_back(32'h148);
    @(negedge clk); idle(); #1;
    n_vec++;
    if (stat_branches !== want_br || stat_mispredicts !== want_mp) begin
      n_err++;
      $display("FAIL stats: got %0d/%0d want %0d/%0d",
               stat_branches, stat_mispredicts, want_br, want_mp);
    end
    sb.push_back(32'h148);
  endtask

  initial begin
    rst = 1'b1; en_f = 1'b0; idle();
    test_reset();
    test_cold_taken();
    test_hysteresis();
    test_stall_redirect();
    test_tag_alias();
    test_wrap();
    test_stats();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
